// File: rtl/dff_pkg.sv
// Shared helpers for the dff_pipe delay line.
// Holds the reset level and the occupancy-width helpers.
package dff_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    function automatic int clog2(input int v);
        int n;
        n = 0;
        while ((1 << n) < v) begin
            n++;
        end
        return n;
    endfunction

    // Occupancy counts 0..depth inclusive, hence depth+1 codes.
    function automatic int occw(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One stage of the delay line: a data word plus its valid bit.
// Reset beats clear, clear beats enable.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    always_ff @(posedge clk) begin
        if (r == RST_ACTIVE) begin
            q     <= RST_VAL;
            q_vld <= 1'b0;
        end else if (clr) begin
            // Data is kept so the output word stays stable.
            q_vld <= 1'b0;
        end else if (en) begin
            q     <= d;
            q_vld <= d_vld;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage registered delay line with per-stage valid,
// stall, flush and an occupancy count.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     r,
    input  logic                     en,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         d,
    input  logic                     d_vld,
    output logic [WIDTH-1:0]         q,
    output logic                     q_vld,
    output logic [occw(DEPTH)-1:0]   occ
);

    localparam int OCCW = occw(DEPTH);

    logic [WIDTH-1:0] data [DEPTH+1];
    logic [DEPTH:0]   vld;
    logic [OCCW-1:0]  occ_nxt;

    assign data[0] = d;
    assign vld[0]  = d_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .r     (r),
            .en    (en),
            .clr   (flush),
            .d     (data[i]),
            .d_vld (vld[i]),
            .q     (data[i+1]),
            .q_vld (vld[i+1])
        );
    end

    assign q     = data[DEPTH];
    assign q_vld = vld[DEPTH];

    // Word in minus word out; never leaves 0..DEPTH.
    always_comb begin
        occ_nxt = occ + OCCW'(d_vld) - OCCW'(vld[DEPTH]);
    end

    always_ff @(posedge clk) begin
        if (r == RST_ACTIVE) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else if (en) begin
            occ <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: reset, latency, stall,
// streaming, flush and mid-stream reset.
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       r;
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       d_vld;
    logic [7:0] q;
    logic       q_vld;
    logic [2:0] occ;
    logic [7:0] q2;
    logic       q2_vld;
    logic [2:0] occ2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u_dut (
        .clk   (clk),
        .r     (r),
        .en    (en),
        .flush (flush),
        .d     (d),
        .d_vld (d_vld),
        .q     (q),
        .q_vld (q_vld),
        .occ   (occ)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h5A)) u_dut5a (
        .clk   (clk),
        .r     (r),
        .en    (en),
        .flush (flush),
        .d     (d),
        .d_vld (d_vld),
        .q     (q2),
        .q_vld (q2_vld),
        .occ   (occ2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev,
                           input logic [7:0] eq, input logic [2:0] eo);
        chk({tag, ".q_vld"}, 32'(q_vld), 32'(ev));
        if (ev) chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".occ"}, 32'(occ), 32'(eo));
        chk({tag, ".occ2"}, 32'(occ2), 32'(eo));
    endtask

    initial begin
        logic [7:0] lq [7];
        logic       lv [7];
        logic [2:0] lo [7];
        logic [7:0] sq [10];
        logic       sv [10];
        logic [2:0] so [10];

        r = 1'b0; en = 1'b1; flush = 1'b0; d = 8'hA5; d_vld = 1'b1;
        step();
        step();
        chk("rst.q", 32'(q), 32'h00);
        chk("rst.q_vld", 32'(q_vld), 32'h0);
        chk("rst.occ", 32'(occ), 32'h0);
        chk("rst.q2", 32'(q2), 32'h5A);
        chk("rst.q2_vld", 32'(q2_vld), 32'h0);

        r = 1'b1; d = 8'h00; d_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("post_rst", 1'b0, 8'h00, 3'd0);
        end

        lq = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        lv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        lo = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 7; i++) begin
            d     = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 :
                    (i == 2) ? 8'h33 : 8'h00;
            d_vld = (i < 3);
            step();
            chk_out("lat", lv[i], lq[i], lo[i]);
        end

        d = 8'h11; d_vld = 1'b1;
        step();
        d = 8'h22;
        step();
        chk_out("stall.load", 1'b0, 8'h00, 3'd2);
        en = 1'b0; d = 8'hFF; d_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall.hold", 1'b0, 8'h00, 3'd2);
        end
        en = 1'b1; d = 8'h00; d_vld = 1'b0;
        step();
        chk_out("stall.r1", 1'b0, 8'h00, 3'd2);
        step();
        chk_out("stall.r2", 1'b1, 8'h11, 3'd2);
        step();
        chk_out("stall.r3", 1'b1, 8'h22, 3'd1);
        step();
        chk_out("stall.r4", 1'b0, 8'h00, 3'd0);

        sq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02,
               8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
        sv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        so = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4,
               3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 10; i++) begin
            d     = (i < 6) ? 8'(i + 1) : 8'h00;
            d_vld = (i < 6);
            step();
            chk_out("stream", sv[i], sq[i], so[i]);
        end

        d_vld = 1'b1;
        d = 8'hA1;
        step();
        d = 8'hA2;
        step();
        d = 8'hA3;
        step();
        chk_out("fl.load", 1'b0, 8'h00, 3'd3);
        flush = 1'b1; d = 8'hB0; d_vld = 1'b1;
        step();
        chk("fl.q", 32'(q), 32'h00);
        chk_out("fl", 1'b0, 8'h00, 3'd0);
        flush = 1'b0; d = 8'hC1; d_vld = 1'b1;
        step();
        chk_out("fl.w1", 1'b0, 8'h00, 3'd1);
        d = 8'h00; d_vld = 1'b0;
        step();
        chk_out("fl.w2", 1'b0, 8'h00, 3'd1);
        step();
        chk_out("fl.w3", 1'b0, 8'h00, 3'd1);
        step();
        chk_out("fl.w4", 1'b1, 8'hC1, 3'd1);
        step();
        chk_out("fl.w5", 1'b0, 8'h00, 3'd0);

        d_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h31 + i);
            step();
        end
        chk_out("mid.full", 1'b1, 8'h31, 3'd4);
        r = 1'b0; d = 8'h77;
        step();
        chk("mid.q", 32'(q), 32'h00);
        chk("mid.q2", 32'(q2), 32'h5A);
        chk("mid.q2_vld", 32'(q2_vld), 32'h0);
        chk_out("mid", 1'b0, 8'h00, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
